reg_file_param: RTL

//  Parametrised successor to the 8x8 CPU register file: generic width/depth, two async read ports,
//  one sync write port gated by RESET and data-memory BUSYWAIT. Adds optional write->read bypass,

---
 rtl/reg_file_param.sv | 117 +++++++++++
 1 files changed

// File: rtl/reg_file_param.sv
// reg_file_param -- parametrised CPU register file with a pending-load scoreboard.
//
// Generic DATA_WIDTH x NUM_REGS register file with two combinational read ports
// and one synchronous write port. Writes are blocked while RESET is high or while
// the data memory is stalled (BUSYWAIT). Optional features:
//   BYPASS   = 1 : read ports forward the write data of the current cycle.
//   ZERO_REG = 1 : register 0 always reads 0, ignores writes and is never pending.
// A per-register scoreboard marks a register pending when a memory load targeting
// it is issued and clears it when the writeback lands, flagging RAW hazards.
//
// Ports
//   CLK, RESET                 clock, synchronous active-high reset
//   IN, INADDRESS, WRITE       write data / index / enable
//   BUSYWAIT                   memory stall; freezes writes and scoreboard
//   OUT1ADDRESS, OUT1          read port 1 index / data
//   OUT2ADDRESS, OUT2          read port 2 index / data
//   LOAD_ISSUE, LOAD_ADDRESS   load issued this cycle and its destination register
//   HAZARD1, HAZARD2           pending flag of the register addressed by each read port
//   PENDING                    full scoreboard vector
module reg_file_param #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 8,
  parameter int BYPASS     = 0,
  parameter int ZERO_REG   = 0,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] IN,
  input  logic [AW-1:0]         INADDRESS,
  input  logic                  WRITE,
  input  logic                  BUSYWAIT,
  input  logic [AW-1:0]         OUT1ADDRESS,
  input  logic [AW-1:0]         OUT2ADDRESS,
  output logic [DATA_WIDTH-1:0] OUT1,
  output logic [DATA_WIDTH-1:0] OUT2,
  input  logic                  LOAD_ISSUE,
  input  logic [AW-1:0]         LOAD_ADDRESS,
  output logic                  HAZARD1,
  output logic                  HAZARD2,
  output logic [NUM_REGS-1:0]   PENDING
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   pending_q;
  logic [NUM_REGS-1:0]   pending_d;

  logic wr_en;
  logic wr_ok;
  logic ld_ok;

  // wr_ok additionally drops writes aimed at the hard-wired zero register,
  // so it is the single condition for both storage and forwarding.
  assign wr_en = WRITE & ~RESET & ~BUSYWAIT;
  assign wr_ok = wr_en & ~((ZERO_REG != 0) && (INADDRESS == '0));
  assign ld_ok = LOAD_ISSUE & ~RESET & ~BUSYWAIT
               & ~((ZERO_REG != 0) && (LOAD_ADDRESS == '0));

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [AW-1:0] addr);
    logic [DATA_WIDTH-1:0] val;
    if ((ZERO_REG != 0) && (addr == '0)) begin
      val = '0;
    end else if ((BYPASS != 0) && wr_ok && (INADDRESS == addr)) begin
      val = IN;
    end else begin
      val = regs_q[addr];
    end
    return val;
  endfunction

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[INADDRESS] = IN;
    end
  end

  // Set has priority over clear: a new load to a register whose previous
  // load is completing this cycle leaves the register pending.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ld_ok && (LOAD_ADDRESS == AW'(i))) begin
        pending_d[i] = 1'b1;
      end else if (wr_en && (INADDRESS == AW'(i))) begin
        pending_d[i] = 1'b0;
      end
    end
    if (ZERO_REG != 0) begin
      pending_d[0] = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  // Read ports and hazard flags are purely combinational; the scoreboard is
  // deliberately not bypassed, so a clearing write is visible one cycle later.
  always_comb begin
    OUT1    = read_port(OUT1ADDRESS);
    OUT2    = read_port(OUT2ADDRESS);
    HAZARD1 = pending_q[OUT1ADDRESS];
    HAZARD2 = pending_q[OUT2ADDRESS];
    PENDING = pending_q;
  end

endmodule
